// File: rtl/tpu_pkg.sv
// Shared TPU control-path types: the decoded instruction word, its reset value,
// and the default look-ahead queue depth.
package tpu_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] operand;
  } instr_type;

  localparam instr_type INIT_INSTR = '{opcode: 8'h00, operand: 16'h0000};

  localparam int LAQ_DEPTH = 4;

endpackage

// File: rtl/look_ahead_queue_mem.sv
// Storage array for the look-ahead queue: one write port, asynchronous read.
// Entries are cleared to INIT_INSTR on reset.
module look_ahead_queue_mem
  import tpu_pkg::*;
#(
  parameter int DEPTH = LAQ_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [PW-1:0]   i_wrAddr,
  input  instr_type       i_wrData,
  input  logic [PW-1:0]   i_rdAddr,
  output instr_type       o_rdData
);

  instr_type r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= INIT_INSTR;
      end
    end else if (i_we) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/look_ahead_queue.sv
// Multi-entry instruction look-ahead queue: buffers decoded instructions and
// issues one per cycle while downstream is idle. Define LOOK_AHEAD_QUEUE_BYPASS_EN
// to let an empty-queue write issue on the same edge.
module look_ahead_queue
  import tpu_pkg::*;
#(
  parameter int DEPTH = LAQ_DEPTH,
  parameter int AFULL_LEVEL = DEPTH - 1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  instr_type       instr_in,
  input  logic            instr_write,
  input  logic            instr_busy,
  output instr_type       instr_out,
  output logic            instr_read,
  output instr_type       instr_next,
  output logic            instr_next_valid,
  output logic [CW-1:0]   instr_count,
  output logic            instr_full,
  output logic            instr_almost_full,
  output logic            instr_overflow
);

  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  instr_type     r_instrOut;
  logic          r_instrRead;
  logic          r_overflow;

  instr_type     w_head;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_bypass;
  logic          w_drop;

  assign w_empty = (r_count == '0);
  assign w_pop   = enable & ~instr_busy & ~w_empty;

`ifdef LOOK_AHEAD_QUEUE_BYPASS_EN
  assign w_bypass = enable & instr_write & ~instr_busy & w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // A full queue still accepts a write when the head leaves on the same edge.
  assign w_push = enable & instr_write & ~w_bypass &
                  ((r_count < CW'(DEPTH)) | w_pop);
  assign w_drop = enable & instr_write & ~w_bypass & ~w_push;

  look_ahead_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_push),
    .i_wrAddr (r_wrPtr),
    .i_wrData (instr_in),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr     <= '0;
      r_wrPtr     <= '0;
      r_count     <= '0;
      r_instrOut  <= INIT_INSTR;
      r_instrRead <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_instrRead <= w_pop | w_bypass;
      if (w_pop) begin
        r_instrOut <= w_head;
        r_rdPtr    <= r_rdPtr + PW'(1);
      end else if (w_bypass) begin
        r_instrOut <= instr_in;
      end
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign instr_out         = r_instrOut;
  assign instr_read        = r_instrRead;
  assign instr_next        = w_empty ? INIT_INSTR : w_head;
  assign instr_next_valid  = ~w_empty;
  assign instr_count       = r_count;
  assign instr_full        = (r_count == CW'(DEPTH));
  assign instr_almost_full = (r_count >= CW'(AFULL_LEVEL));
  assign instr_overflow    = r_overflow;

endmodule

// File: doc/look_ahead_queue.md
# look_ahead_queue

Parametrised, multi-entry successor to the single-slot instruction look-ahead stage of the TPU control path. Accepts decoded instructions from the instruction fetch side, queues up to DEPTH of them, and issues one per cycle to the control units while they are not busy. Exposes the next pending instruction (look-ahead) so downstream units can prepare, and reports occupancy, almost-full and overflow.

## Interface
- DEPTH, 4: queue entries; power of two, ≥ 2.
- AFULL_LEVEL, DEPTH-1: occupancy at or above which instr_almost_full asserts; 1..DEPTH.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  global enable; 0 freezes the block.
- instr_in  in  instr_type  instruction to enqueue.
- instr_write  in  1  enqueue strobe, sampled at rising edge.
- instr_busy  in  1  downstream busy; no issue while high.
- instr_out  out  instr_type  issued instruction, registered.
- instr_read  out  1  one-cycle strobe: instr_out carries a newly issued instruction.
- instr_next  out  instr_type  current queue head (next to issue); INIT_INSTR when empty.
- instr_next_valid  out  1  queue non-empty.
- instr_count  out  $clog2(DEPTH+1)  occupancy.
- instr_full  out  1  instr_count == DEPTH.
- instr_almost_full  out  1  instr_count ≥ AFULL_LEVEL.
- instr_overflow  out  1  sticky: a write was dropped.

## Operation
- Circular buffer, read/write pointers $clog2(DEPTH) bits, natural wrap at DEPTH-1 → 0; separate occupancy counter.
- Pop condition at edge: enable & !instr_busy & (count > 0). On pop: instr_out ← head, instr_read ← 1, read pointer advances. Otherwise instr_read ← 0, instr_out holds its value.
- Push condition: enable & instr_write & (count < DEPTH or pop same edge). Push stores instr_in at write pointer.
- Full with write and pop on same edge: both occur, count unchanged.
- Full with write, no pop: write dropped, instr_overflow ← 1 (stays until rst), count unchanged.
- enable = 0: no push, no pop, instr_read ← 0, writes ignored without setting overflow.
- Empty with write, no bypass: entry stored; earliest issue next edge.
- instr_next, instr_next_valid, instr_count, instr_full, instr_almost_full derive combinationally from registered state.

## Timing
- Reset values: instr_out = INIT_INSTR, instr_read = 0, instr_count = 0, instr_next = INIT_INSTR, instr_next_valid = 0, instr_full = 0, instr_almost_full = 0 (for AFULL_LEVEL ≥ 1), instr_overflow = 0, pointers 0.
- Reset mid-operation: all entries discarded immediately (asynchronous); first post-reset edge behaves as empty queue.
- Latency write → instr_read: 2 edges without bypass (store at N, issue at N+1, instr_read high in cycle after N+1).
- Throughput: one issue per cycle while not busy and non-empty; instr_busy sampled at the same edge as the pop decision.
- instr_busy high holds the queue; instr_read is 0 every cycle following a busy edge.

## Configuration
- LOOK_AHEAD_QUEUE_BYPASS_EN defined: when count == 0, enable = 1, instr_write = 1, instr_busy = 0, instr_in goes straight to instr_out with instr_read ← 1 at the same edge; nothing stored. Write → instr_read latency 1 edge.
- Undefined: no bypass path; empty-queue writes always stored first (latency 2).

## Structure
- tpu_pkg: instr_type, INIT_INSTR (existing); add LAQ_DEPTH default constant.
- Sub-module look_ahead_queue_mem: DEPTH × instr_type register array, one write port, asynchronous read at read pointer; reset clears entries to INIT_INSTR.
- Top holds pointers, counter, pop/push logic, output registers, overflow flag, bypass.

## Test plan
- Reset then idle: all outputs at reset values for 5 cycles; instr_out = INIT_INSTR.
- Single write opcode 8'h08, busy 0 → instr_read high exactly one cycle, 2 edges after write (1 with bypass), instr_out.opcode = 8'h08, count back to 0.
- Busy held, write 8'h20, 8'h80, 8'h20, 8'h40 (DEPTH 4) → count 4, full = 1, almost_full from count 3, instr_next.opcode = 8'h20; release busy → four consecutive issues in order 20, 80, 20, 40.
- Full, busy held, fifth write 8'h01 → dropped, overflow = 1 and stays; same write with busy low → accepted, count stays 4, overflow unchanged.
- Wrap-around: 10 writes/pops interleaved across DEPTH boundary → issue order equals write order, no loss.
- Assert rst mid-stream with count 3 → outputs to reset values without clock edge; subsequent write 8'h08 issues normally.
